// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit
//
// Multi-cycle sequencer for the RV32I datapath. It fetches one instruction
// at a time and decodes R-type, I-type ALU, LW and SW. It then drives the
// datapath control, PC, IR and data-memory strobes through a fixed state
// sequence. PC update and register write each happen once per instruction,
// however many memory wait states occur.
//
// Handshake (both memories): the request stays high every cycle in its
// waiting state until the matching ack is seen high in the same cycle. The
// request drops in the following cycle because the state changes. An ack
// that arrives while its request is low has no effect.
//
// Ports:
//   clk               system clock, rising edge
//   reset             asynchronous, active-low reset
//   instr[31:0]       IR contents, stable from DECODE until the next FETCH
//   imem_ack          instruction memory data valid this cycle
//   dmem_ack          data memory access completes this cycle
//   imem_req          instruction fetch request
//   ir_we             latch instruction memory data into IR
//   pc_we             load PC with PC+4
//   alu_control_en    ALU operation code
//   imm_en            1: immediate is ALU operand B, 0: RS2
//   register_write_en regfile write strobe
//   wb_sel            0: ALU result to regfile, 1: mem_rdata
//   dmem_req          data memory request
//   dmem_we           data memory write (qualified by dmem_req)
//   illegal_instr     one-cycle pulse on an unsupported instruction
//   instret           retired legal instruction count, wraps
//   state_dbg         current FSM state, for debug and checkers
module multicycle_control_unit #(
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          instr,
  input  logic                 imem_ack,
  input  logic                 dmem_ack,
  output logic                 imem_req,
  output logic                 ir_we,
  output logic                 pc_we,
  output logic [3:0]           alu_control_en,
  output logic                 imm_en,
  output logic                 register_write_en,
  output logic                 wb_sel,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic                 illegal_instr,
  output logic [INSTRET_W-1:0] instret,
  output logic [2:0]           state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5
  } state_t;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_STOR = 7'b0100011;

  state_t state;

  // IR is stable from DECODE onward, so the instruction class is decoded
  // combinationally in every state rather than being captured.
  logic [6:0] opcode;
  logic [2:0] f3;
  logic       rd_nz;
  logic       is_r, is_i, is_ld, is_st, is_alu, is_mem, legal;
  logic [3:0] dec_alu;
  logic       dec_imm;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign rd_nz  = (instr[11:7] != 5'd0);
  assign is_r   = (opcode == OP_R);
  assign is_i   = (opcode == OP_I);
  assign is_ld  = (opcode == OP_LOAD) && (f3 == 3'b010);
  assign is_st  = (opcode == OP_STOR) && (f3 == 3'b010);
  assign is_alu = is_r || is_i;
  assign is_mem = is_ld || is_st;
  assign legal  = is_alu || is_mem;

  always_comb begin
    dec_alu = 4'b0000;
    dec_imm = 1'b0;
    if (is_r) begin
      // instr[30] distinguishes SUB/SRA; only meaningful for f3 000 and 101.
      dec_alu = {instr[30] & ((f3 == 3'b000) | (f3 == 3'b101)), f3};
      dec_imm = 1'b0;
    end else if (is_i) begin
      // For I-ALU, instr[30] is an immediate bit except in SRAI.
      dec_alu = {instr[30] & (f3 == 3'b101), f3};
      dec_imm = 1'b1;
    end else if (is_mem) begin
      dec_alu = 4'b0000;
      dec_imm = 1'b1;
    end
  end

  // Outputs depend on state and instr. The only same-cycle strobes are
  // ir_we and the store pc_we, which are qualified by the ack their
  // state is waiting on.
  always_comb begin
    imem_req          = 1'b0;
    ir_we             = 1'b0;
    pc_we             = 1'b0;
    alu_control_en    = 4'b0000;
    imm_en            = 1'b0;
    register_write_en = 1'b0;
    wb_sel            = 1'b0;
    dmem_req          = 1'b0;
    dmem_we           = 1'b0;
    illegal_instr     = 1'b0;
    case (state)
      S_FETCH: begin
        imem_req = 1'b1;
        ir_we    = imem_ack;
      end
      S_DECODE: begin
        if (legal) begin
          alu_control_en = dec_alu;
          imm_en         = dec_imm;
        end else begin
          illegal_instr = 1'b1;
          pc_we         = 1'b1;
        end
      end
      S_EXEC: begin
        alu_control_en = dec_alu;
        imm_en         = dec_imm;
        if (is_alu) begin
          register_write_en = rd_nz;
          pc_we             = 1'b1;
        end
      end
      S_MEM: begin
        alu_control_en = dec_alu;
        imm_en         = dec_imm;
        dmem_req       = 1'b1;
        dmem_we        = is_st;
        pc_we          = is_st & dmem_ack;
      end
      S_WB: begin
        alu_control_en    = dec_alu;
        imm_en            = dec_imm;
        register_write_en = rd_nz;
        wb_sel            = 1'b1;
        pc_we             = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      instret <= '0;
    end else begin
      case (state)
        S_IDLE:   state <= S_FETCH;
        S_FETCH:  if (imem_ack) state <= S_DECODE;
        S_DECODE: state <= legal ? S_EXEC : S_FETCH;
        S_EXEC: begin
          if (is_mem) begin
            state <= S_MEM;
          end else begin
            state   <= S_FETCH;
            instret <= instret + INSTRET_W'(1);
          end
        end
        S_MEM: begin
          if (dmem_ack) begin
            if (is_st) begin
              state   <= S_FETCH;
              instret <= instret + INSTRET_W'(1);
            end else begin
              state <= S_WB;
            end
          end
        end
        S_WB: begin
          state   <= S_FETCH;
          instret <= instret + INSTRET_W'(1);
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit. Inputs change on the falling
// edge and outputs are sampled 1 time unit later. The counter is built
// 3 bits wide so that wrap-around is reached quickly.
module tb_multicycle_control_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        imem_ack, dmem_ack;
  logic        imem_req, ir_we, pc_we, imm_en, register_write_en;
  logic        wb_sel, dmem_req, dmem_we, illegal_instr;
  logic [3:0]  alu_control_en;
  logic [2:0]  instret;
  logic [2:0]  state_dbg;

  int n_vec = 0;
  int n_err = 0;

  multicycle_control_unit #(.INSTRET_W(3)) dut (
    .clk(clk), .reset(reset), .instr(instr),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .imem_req(imem_req), .ir_we(ir_we), .pc_we(pc_we),
    .alu_control_en(alu_control_en), .imm_en(imm_en),
    .register_write_en(register_write_en), .wb_sel(wb_sel),
    .dmem_req(dmem_req), .dmem_we(dmem_we),
    .illegal_instr(illegal_instr), .instret(instret),
    .state_dbg(state_dbg)
  );

  // clock/reset block
  always #5 clk = ~clk;

  logic [12:0] outs;
  assign outs = {imem_req, ir_we, pc_we, alu_control_en, imm_en,
                 register_write_en, wb_sel, dmem_req, dmem_we, illegal_instr};

  // Expected output vector, fields in the same order as outs.
  function automatic logic [12:0] ev(input logic ireq, input logic irwe,
    input logic pcwe, input logic [3:0] alu, input logic imm, input logic rwe,
    input logic wb, input logic dreq, input logic dwe, input logic ill);
    return {ireq, irwe, pcwe, alu, imm, rwe, wb, dreq, dwe, ill};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle: apply inputs on the falling edge, settle, return.
  task automatic cyc(input logic ia, input logic da, input logic [31:0] ins);
    @(negedge clk);
    imem_ack = ia;
    dmem_ack = da;
    instr    = ins;
    #1;
  endtask

  // Zero-wait fetch of ins; also checks instret from the previous instruction.
  task automatic fetch_ack(input logic [31:0] ins, input logic [2:0] exp_ret);
    cyc(1'b1, 1'b0, ins);
    chk("fetch_ack", 32'(outs), 32'(ev(1,1,0,4'h0,0,0,0,0,0,0)));
    chk("instret_at_fetch", 32'(instret), 32'(exp_ret));
  endtask

  task automatic alu_instr(input logic [31:0] ins, input logic [2:0] ret,
                           input logic [3:0] alu, input logic imm, input logic rwe);
    fetch_ack(ins, ret);
    cyc(1'b0, 1'b0, ins);
    chk("alu_decode", 32'(outs), 32'(ev(0,0,0,alu,imm,0,0,0,0,0)));
    cyc(1'b0, 1'b0, ins);
    chk("alu_exec", 32'(outs), 32'(ev(0,0,1,alu,imm,rwe,0,0,0,0)));
  endtask

  localparam logic [31:0] I_SUB  = 32'h402081B3;
  localparam logic [31:0] I_SRAI = 32'h4020D293;
  localparam logic [31:0] I_ADDI = 32'h00100013;
  localparam logic [31:0] I_LW   = 32'h00802203;
  localparam logic [31:0] I_SW   = 32'h00112223;
  localparam logic [31:0] I_JAL  = 32'h0000006F;
  localparam logic [31:0] I_LH   = 32'h00801203;

  initial begin
    reset = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0; instr = 32'h0;
    #1 reset = 1'b0;

    // reset held for 3 cycles
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 32'h0);
      chk("reset_outs", 32'(outs), 32'h0);
      chk("reset_instret", 32'(instret), 32'h0);
    end
    @(negedge clk); reset = 1'b1; #1;
    chk("idle_outs", 32'(outs), 32'h0);
    // FETCH with wait states; dmem_ack must be ignored here
    cyc(1'b0, 1'b1, 32'h0);
    chk("fetch_wait1", 32'(outs), 32'(ev(1,0,0,4'h0,0,0,0,0,0,0)));
    cyc(1'b0, 1'b0, 32'h0);
    chk("fetch_wait2", 32'(outs), 32'(ev(1,0,0,4'h0,0,0,0,0,0,0)));

    // sub x3,x1,x2 / srai x5,x1,2 / addi x0,x0,1 (no write to x0)
    alu_instr(I_SUB,  3'd0, 4'b1000, 1'b0, 1'b1);
    alu_instr(I_SRAI, 3'd1, 4'b1101, 1'b1, 1'b1);
    alu_instr(I_ADDI, 3'd2, 4'b0000, 1'b1, 1'b0);

    // lw x4,8(x0) with dmem_ack two cycles late; stray ack in EXEC ignored
    fetch_ack(I_LW, 3'd3);
    cyc(1'b0, 1'b0, I_LW);
    chk("lw_decode", 32'(outs), 32'(ev(0,0,0,4'h0,1,0,0,0,0,0)));
    cyc(1'b0, 1'b1, I_LW);
    chk("lw_exec", 32'(outs), 32'(ev(0,0,0,4'h0,1,0,0,0,0,0)));
    cyc(1'b0, 1'b0, I_LW);
    chk("lw_mem_wait1", 32'(outs), 32'(ev(0,0,0,4'h0,1,0,0,1,0,0)));
    cyc(1'b0, 1'b0, I_LW);
    chk("lw_mem_wait2", 32'(outs), 32'(ev(0,0,0,4'h0,1,0,0,1,0,0)));
    cyc(1'b0, 1'b1, I_LW);
    chk("lw_mem_ack", 32'(outs), 32'(ev(0,0,0,4'h0,1,0,0,1,0,0)));
    cyc(1'b0, 1'b0, I_LW);
    chk("lw_wb", 32'(outs), 32'(ev(0,0,1,4'h0,1,1,1,0,0,0)));
    chk("lw_wb_instret", 32'(instret), 32'd3);

    // sw x1,4(x2), zero-wait
    fetch_ack(I_SW, 3'd4);
    cyc(1'b0, 1'b0, I_SW);
    chk("sw_decode", 32'(outs), 32'(ev(0,0,0,4'h0,1,0,0,0,0,0)));
    cyc(1'b0, 1'b0, I_SW);
    chk("sw_exec", 32'(outs), 32'(ev(0,0,0,4'h0,1,0,0,0,0,0)));
    cyc(1'b0, 1'b1, I_SW);
    chk("sw_mem_ack", 32'(outs), 32'(ev(0,0,1,4'h0,1,0,0,1,1,0)));

    // jal: unsupported opcode; lh: load with illegal f3
    fetch_ack(I_JAL, 3'd5);
    cyc(1'b0, 1'b0, I_JAL);
    chk("jal_illegal", 32'(outs), 32'(ev(0,0,1,4'h0,0,0,0,0,0,1)));
    fetch_ack(I_LH, 3'd5);
    cyc(1'b0, 1'b0, I_LH);
    chk("lh_illegal", 32'(outs), 32'(ev(0,0,1,4'h0,0,0,0,0,0,1)));

    // counter wrap: 5 -> 6 -> 7 -> 0 -> 1
    alu_instr(I_ADDI, 3'd5, 4'b0000, 1'b1, 1'b0);
    alu_instr(I_ADDI, 3'd6, 4'b0000, 1'b1, 1'b0);
    alu_instr(I_ADDI, 3'd7, 4'b0000, 1'b1, 1'b0);
    alu_instr(I_ADDI, 3'd0, 4'b0000, 1'b1, 1'b0);

    // reset in the middle of a load's MEM wait
    fetch_ack(I_LW, 3'd1);
    cyc(1'b0, 1'b0, I_LW);
    cyc(1'b0, 1'b0, I_LW);
    cyc(1'b0, 1'b0, I_LW);
    chk("lw2_mem_wait", 32'(outs), 32'(ev(0,0,0,4'h0,1,0,0,1,0,0)));
    @(negedge clk); reset = 1'b0; #1;
    chk("midmem_reset_outs", 32'(outs), 32'h0);
    chk("midmem_reset_instret", 32'(instret), 32'h0);
    cyc(1'b0, 1'b1, I_LW);
    chk("reset_hold_ack", 32'(outs), 32'h0);
    @(negedge clk); reset = 1'b1; dmem_ack = 1'b0; #1;
    chk("post_reset_idle", 32'(outs), 32'h0);
    cyc(1'b0, 1'b0, I_LW);
    chk("post_reset_fetch", 32'(outs), 32'(ev(1,0,0,4'h0,0,0,0,0,0,0)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
